// File: rtl/tone_pkg.sv
// rtl/tone_pkg.sv - shared constants and types for the tone synthesizer
package tone_pkg;

  localparam int DIV_W = 22;
  localparam int VOL_W = 3;

  localparam logic [VOL_W-1:0] VOL_RESET = 3'd3;
  localparam logic [VOL_W-1:0] VOL_MAX   = 3'd7;
  localparam logic [15:0]      VOL_STEP  = 16'h1000;

  // Half-period divisors at 100 MHz, rounded note frequency in Hz
  localparam logic [DIV_W-1:0] NOTE_C4 = 22'd190840;
  localparam logic [DIV_W-1:0] NOTE_D4 = 22'd170068;
  localparam logic [DIV_W-1:0] NOTE_E4 = 22'd151515;
  localparam logic [DIV_W-1:0] NOTE_F4 = 22'd143266;
  localparam logic [DIV_W-1:0] NOTE_G4 = 22'd127551;
  localparam logic [DIV_W-1:0] NOTE_A4 = 22'd113636;
  localparam logic [DIV_W-1:0] NOTE_B4 = 22'd101214;

  typedef enum logic [1:0] {
    VOL_HOLD = 2'd0,
    VOL_INC  = 2'd1,
    VOL_DEC  = 2'd2
  } vol_cmd_e;

  // Decode the two volume pulses; both or neither means hold
  function automatic vol_cmd_e vol_decode(input logic up, input logic dn);
    if (up && !dn) return VOL_INC;
    if (dn && !up) return VOL_DEC;
    return VOL_HOLD;
  endfunction

endpackage

// File: rtl/tone_osc.sv
// rtl/tone_osc.sv - square-wave phase generator with clean restart on divisor change
module tone_osc #(
  parameter int W = tone_pkg::DIV_W
) (
  input  logic         clk_100mhz,
  input  logic         rst_n,
  input  logic [W-1:0] div,
  output logic         phase
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] div_q;
  logic [W-1:0] cnt;

  // Count 0..div-1 and toggle phase on wrap; a new divisor or silence restarts from phase 0
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      cnt   <= '0;
      phase <= 1'b0;
    end else begin
      div_q <= div;
      if ((div != div_q) || (div == '0)) begin
        cnt   <= '0;
        phase <= 1'b0;
      end else if (cnt == (div - ONE)) begin
        cnt   <= '0;
        phase <= ~phase;
      end else begin
        cnt <= cnt + ONE;
      end
    end
  end

endmodule

// File: rtl/tone_synth.sv
// rtl/tone_synth.sv - stereo square-wave tone source with volume, mute and frame-aligned output
module tone_synth #(
  parameter int          DIV_W     = tone_pkg::DIV_W,
  parameter logic [15:0] VOL_STEP  = tone_pkg::VOL_STEP,
  parameter logic [2:0]  VOL_RESET = tone_pkg::VOL_RESET
) (
  input  logic                clk_100mhz,
  input  logic                rst_n,
  input  logic                audio_lrck,
  input  logic [DIV_W-1:0]    note_div_l,
  input  logic [DIV_W-1:0]    note_div_r,
  input  logic                vol_up,
  input  logic                vol_dn,
  input  logic                mute,
  output logic signed [15:0]  audio_left,
  output logic signed [15:0]  audio_right,
  output logic [2:0]          vol_level,
  output logic                sample_stb
);

  import tone_pkg::*;

  logic     phase_l;
  logic     phase_r;
  logic     lrck_s1;
  logic     lrck_s2;
  logic     lrck_s3;
  logic     lrck_rise;
  vol_cmd_e vol_cmd;
  logic [15:0] amp;
  logic [15:0] samp_l;
  logic [15:0] samp_r;

  tone_osc #(.W(DIV_W)) u_osc_l (
    .clk_100mhz (clk_100mhz),
    .rst_n      (rst_n),
    .div        (note_div_l),
    .phase      (phase_l)
  );

  tone_osc #(.W(DIV_W)) u_osc_r (
    .clk_100mhz (clk_100mhz),
    .rst_n      (rst_n),
    .div        (note_div_r),
    .phase      (phase_r)
  );

  assign vol_cmd = vol_decode(vol_up, vol_dn);

  // Saturating volume counter driven by the decoded pulse command
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      vol_level <= VOL_RESET;
    end else begin
      case (vol_cmd)
        VOL_INC: if (vol_level != VOL_MAX) vol_level <= vol_level + 3'd1;
        VOL_DEC: if (vol_level != 3'd0)    vol_level <= vol_level - 3'd1;
        default: vol_level <= vol_level;
      endcase
    end
  end

  // Two-flop synchronizer plus one history flop for lrck rising-edge detection
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      lrck_s1 <= 1'b0;
      lrck_s2 <= 1'b0;
      lrck_s3 <= 1'b0;
    end else begin
      lrck_s1 <= audio_lrck;
      lrck_s2 <= lrck_s1;
      lrck_s3 <= lrck_s2;
    end
  end

  assign lrck_rise = lrck_s2 & ~lrck_s3;

  // Map registered phase and volume to signed samples; silence wins over everything
  always_comb begin
    amp    = 16'(vol_level) * VOL_STEP;
    samp_l = 16'd0;
    samp_r = 16'd0;
    if (!(mute || (note_div_l == '0) || (vol_level == 3'd0))) begin
      samp_l = phase_l ? amp : (~amp + 16'd1);
    end
    if (!(mute || (note_div_r == '0) || (vol_level == 3'd0))) begin
      samp_r = phase_r ? amp : (~amp + 16'd1);
    end
  end

  // Capture both channels together only on a frame-clock rise so a serial word is never torn
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      audio_left  <= '0;
      audio_right <= '0;
      sample_stb  <= 1'b0;
    end else begin
      sample_stb <= lrck_rise;
      if (lrck_rise) begin
        audio_left  <= samp_l;
        audio_right <= samp_r;
      end
    end
  end

endmodule
